// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory controller.
package idli_pkg;

    typedef enum logic {
        SQI_IO_MODE_IN  = 1'b0,
        SQI_IO_MODE_OUT = 1'b1
    } sqi_io_mode_t;

    typedef enum logic [2:0] {
        SQI_STATE_INIT,
        SQI_STATE_IDLE,
        SQI_STATE_CMD,
        SQI_STATE_ADDR,
        SQI_STATE_DUMMY,
        SQI_STATE_DATA,
        SQI_STATE_END
    } sqi_state_t;

    localparam logic [7:0]  SQI_CMD_READ      = 8'h03;
    localparam logic [7:0]  SQI_CMD_WRITE     = 8'h02;
    localparam logic [7:0]  SQI_CMD_EQIO      = 8'h38;
    localparam int unsigned SQI_DUMMY_NIBBLES = 2;

endpackage

// File: rtl/idli_sqi_init_m.sv
// EQIO serialiser: shifts SQI_CMD_EQIO out MSB first on SIO[0] in SPI mode,
// two cycles per bit (sck low, then high). Used only with IDLI_SQI_MODE_INIT_EN.
module idli_sqi_init_m
    import idli_pkg::*;
(
    input  logic i_sqi_gck,
    input  logic i_sqi_rst_n,
    input  logic i_init_en,
    output logic o_init_sck,
    output logic o_init_sio,
    output logic o_init_done
);

    logic [3:0] cnt_q;

    always_ff @(posedge i_sqi_gck) begin
        if (!i_sqi_rst_n || !i_init_en) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign o_init_sck  = cnt_q[0];
    assign o_init_sio  = SQI_CMD_EQIO[3'd7 - cnt_q[3:1]];
    assign o_init_done = &cnt_q;

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory controller: command, address, dummy and data nibble sequencing.
// Define IDLI_SQI_MODE_INIT_EN to send EQIO after reset before going idle.
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              i_sqi_gck,
    input  logic              i_sqi_rst_n,
    input  logic              i_sqi_req,
    input  logic              i_sqi_wr,
    input  logic [ADDR_W-1:0] i_sqi_addr,
    output logic              o_sqi_req_acp,
    output logic              o_sqi_data_stb,
    input  logic [3:0]        i_sqi_wdata,
    output logic [3:0]        o_sqi_rdata,
    input  logic              i_sqi_end,
    output logic              o_sqi_sck,
    output logic              o_sqi_cs,
    output sqi_io_mode_t      o_sqi_io_mode,
    input  logic [3:0]        i_sqi_sio,
    output logic [3:0]        o_sqi_sio
);

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(SQI_DUMMY_NIBBLES - 1);

    sqi_state_t        state_q, state_d;
    logic              ph_q;
    logic [7:0]        nib_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wdata_q;
    logic [3:0]        rdata_q;
    logic              last_q;
    logic              rd_stb_q;
    logic              wr_stb;
    logic [7:0]        cmd_byte;
    logic              init_sck, init_sio, init_done;

`ifdef IDLI_SQI_MODE_INIT_EN
    localparam sqi_state_t RST_STATE = SQI_STATE_INIT;

    idli_sqi_init_m u_init (
        .i_sqi_gck   (i_sqi_gck),
        .i_sqi_rst_n (i_sqi_rst_n),
        .i_init_en   (state_q == SQI_STATE_INIT),
        .o_init_sck  (init_sck),
        .o_init_sio  (init_sio),
        .o_init_done (init_done)
    );
`else
    localparam sqi_state_t RST_STATE = SQI_STATE_IDLE;

    assign init_sck  = 1'b0;
    assign init_sio  = 1'b0;
    assign init_done = 1'b1;
`endif

    assign cmd_byte       = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
    assign o_sqi_rdata    = rdata_q;
    assign o_sqi_data_stb = wr_stb | rd_stb_q;

    always_ff @(posedge i_sqi_gck) begin
        if (!i_sqi_rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_sqi_req_acp = 1'b0;
        o_sqi_cs      = 1'b1;
        o_sqi_sck     = 1'b0;
        o_sqi_io_mode = SQI_IO_MODE_IN;
        o_sqi_sio     = '0;
        wr_stb        = 1'b0;
        case (state_q)
            SQI_STATE_INIT: begin
                o_sqi_cs      = 1'b0;
                o_sqi_sck     = init_sck;
                o_sqi_io_mode = SQI_IO_MODE_OUT;
                o_sqi_sio     = {3'b000, init_sio};
                if (init_done) state_d = SQI_STATE_END;
            end
            SQI_STATE_IDLE: begin
                o_sqi_req_acp = 1'b1;
                if (i_sqi_req) state_d = SQI_STATE_CMD;
            end
            SQI_STATE_CMD: begin
                o_sqi_cs      = 1'b0;
                o_sqi_sck     = ph_q;
                o_sqi_io_mode = SQI_IO_MODE_OUT;
                o_sqi_sio     = nib_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];
                if (ph_q && nib_q == 8'd1) state_d = SQI_STATE_ADDR;
            end
            SQI_STATE_ADDR: begin
                o_sqi_cs      = 1'b0;
                o_sqi_sck     = ph_q;
                o_sqi_io_mode = SQI_IO_MODE_OUT;
                o_sqi_sio     = addr_q[ADDR_W-1 -: 4];
                if (ph_q && nib_q == ADDR_LAST) begin
                    // Writes request their first nibble here so it is ready for data phase 0.
                    wr_stb  = wr_q;
                    state_d = wr_q ? SQI_STATE_DATA : SQI_STATE_DUMMY;
                end
            end
            SQI_STATE_DUMMY: begin
                o_sqi_cs  = 1'b0;
                o_sqi_sck = ph_q;
                if (ph_q && nib_q == DUMMY_LAST) state_d = SQI_STATE_DATA;
            end
            SQI_STATE_DATA: begin
                o_sqi_cs  = 1'b0;
                o_sqi_sck = ph_q;
                if (wr_q) begin
                    o_sqi_io_mode = SQI_IO_MODE_OUT;
                    o_sqi_sio     = wdata_q;
                    if (ph_q) begin
                        wr_stb = !last_q;
                        if (last_q) state_d = SQI_STATE_END;
                    end
                end else if (!ph_q && rd_stb_q && i_sqi_end) begin
                    state_d = SQI_STATE_END;
                end
            end
            SQI_STATE_END: begin
                state_d = SQI_STATE_IDLE;
            end
            default: begin
                state_d = SQI_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sqi_gck) begin
        if (!i_sqi_rst_n) begin
            ph_q     <= 1'b0;
            nib_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            last_q   <= 1'b0;
            rd_stb_q <= 1'b0;
        end else begin
            // Read nibble registered in phase 1, strobed to the core one cycle later.
            rd_stb_q <= (state_q == SQI_STATE_DATA) && !wr_q && ph_q;
            if (state_q == SQI_STATE_IDLE) begin
                ph_q   <= 1'b0;
                nib_q  <= '0;
                last_q <= 1'b0;
                if (i_sqi_req) begin
                    wr_q   <= i_sqi_wr;
                    addr_q <= i_sqi_addr;
                end
            end else begin
                ph_q <= ~ph_q;
                if (ph_q) begin
                    nib_q <= (state_d != state_q) ? '0 : nib_q + 8'd1;
                end
                if (state_q == SQI_STATE_ADDR && ph_q) begin
                    addr_q <= addr_q << 4;
                end
                if (state_q == SQI_STATE_DATA && !wr_q && ph_q) begin
                    rdata_q <= i_sqi_sio;
                end
                if (wr_stb) begin
                    wdata_q <= i_sqi_wdata;
                    if (i_sqi_end) last_q <= 1'b1;
                end
            end
        end
    end

endmodule
